// File: rtl/grey_incr_sched_pkg.sv
// Shared definitions for the grey counter increment scheduler:
// default sizing, grant-id width derivation and the round-robin search.
package grey_incr_sched_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int CNT_W_DEF = 5;
    localparam int MAX_NREQ  = 8;
    localparam int PICK_W    = 3;

    // Grant id width for a given channel count; never narrower than one bit.
    function automatic int f_id_w(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

    // First set request at or after ptr, ascending, wrapping modulo nreq.
    // Returns 0 when nothing is requested; callers qualify with |req.
    function automatic logic [PICK_W-1:0] f_rr_pick(
        input logic [MAX_NREQ-1:0] req,
        input logic [PICK_W-1:0]   ptr,
        input int                  nreq
    );
        logic [PICK_W-1:0] pick;
        logic [PICK_W-1:0] idx;
        logic              found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            idx = PICK_W'((int'(ptr) + k) % nreq);
            if ((k < nreq) && !found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/grey_div_chan.sv
// One scheduler channel: programmable divider that raises a tick, plus the
// pending flag the arbiter consumes and a sticky overflow for lost ticks.
module grey_div_chan
    import grey_incr_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             w_rst,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_gnt,
    input  logic             i_ovf_clr,
    output logic             o_pend,
    output logic             o_ovf
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;
    logic             r_ovf;
    logic             w_tick;

    // >= rather than == so a divisor lowered below the count ticks at once
    // instead of running the counter round through 2^CNT_W.
    assign w_tick = i_en && (r_cnt >= i_div);

    // NOTE: non-blocking assignments for every register so all channels and
    // the arbiter sample the same pre-edge pend/grant values.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (!i_en || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_pend <= (r_pend && !i_gnt) || w_tick;

            if (w_tick && r_pend && !i_gnt) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_pend = r_pend;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/grey_incr_sched.sv
// Round-robin scheduler sharing one grey_code6_sync increment input among
// NREQ divider channels; one registered incr_sync pulse per grant.
module grey_incr_sched
    import grey_incr_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ID_W  = f_id_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  w_rst,
    input  logic                  go,
    input  logic [NREQ-1:0]       en,
    input  logic [NREQ*CNT_W-1:0] div,
    input  logic [NREQ-1:0]       ovf_clr,
    output logic                  incr_sync,
    output logic [ID_W-1:0]       gnt_id,
    output logic [NREQ-1:0]       pend,
    output logic [NREQ-1:0]       ovf,
    output logic                  busy
);

    logic                r_incr_sync;
    logic [ID_W-1:0]     r_gnt_id;
    logic [ID_W-1:0]     r_ptr;

    logic [MAX_NREQ-1:0] w_req;
    logic [PICK_W-1:0]   w_pick;
    logic [ID_W-1:0]     w_win;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic                w_grant;

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a signal unassigned and infers a latch.
    always_comb begin
        w_req            = '0;
        w_req[NREQ-1:0]  = pend;
        w_pick           = f_rr_pick(w_req, PICK_W'(r_ptr), NREQ);
        w_win            = w_pick[ID_W-1:0];
        w_grant          = go && (|pend);
        w_ptr_nxt        = (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_chan
            grey_div_chan #(
                .CNT_W (CNT_W)
            ) u_chan (
                .clk       (clk),
                .w_rst     (w_rst),
                .i_en      (en[gi]),
                .i_div     (div[gi*CNT_W +: CNT_W]),
                .i_gnt     (w_grant && (w_win == ID_W'(gi))),
                .i_ovf_clr (ovf_clr[gi]),
                .o_pend    (pend[gi]),
                .o_ovf     (ovf[gi])
            );
        end
    endgenerate

    // gnt_id and the pointer hold between grants; only incr_sync drops.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_incr_sync <= 1'b0;
            r_gnt_id    <= '0;
            r_ptr       <= '0;
        end else if (w_grant) begin
            r_incr_sync <= 1'b1;
            r_gnt_id    <= w_win;
            r_ptr       <= w_ptr_nxt;
        end else begin
            r_incr_sync <= 1'b0;
        end
    end

    assign incr_sync = r_incr_sync;
    assign gnt_id    = r_gnt_id;
    assign busy      = |pend;

endmodule
